sat_counter: RTL and testbench

Parametrised up/down counter, the next generation of the team's 4-bit `counter`. It keeps the same per-cycle update: reload, add a valid increment, subtract a valid decrement, with a combinational `value_next` look-ahead. New in this block: configurable width and step width, a selectable wrap or saturate overflow mode, sticky overflow/underflow flags with a clear, and registered `zero`/`max` status flags. It sits beside credit and occupancy tracking logic that needs bounded counts.

---
 rtl/sat_counter_if.sv | 40 ++++
 rtl/sat_counter.sv | 73 +++++++
 tb/tb_sat_counter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sat_counter_if.sv
// sat_counter_if: control and status bundle for sat_counter.
// master drives the update controls, slave returns the count and flags.
interface sat_counter_if #(
    parameter int WIDTH      = 4,
    parameter int STEP_WIDTH = 2
);
    logic                  reinit;
    logic [WIDTH-1:0]      initial_value;
    logic                  incr_valid;
    logic [STEP_WIDTH-1:0] incr;
    logic                  decr_valid;
    logic [STEP_WIDTH-1:0] decr;
    logic                  flag_clear;
    logic [WIDTH-1:0]      value;
    logic [WIDTH-1:0]      value_next;
    logic                  overflow;
    logic                  underflow;
    logic                  zero;
    logic                  max;

    modport master (
        output reinit, initial_value,
        output incr_valid, incr,
        output decr_valid, decr,
        output flag_clear,
        input  value, value_next,
        input  overflow, underflow,
        input  zero, max
    );

    modport slave (
        input  reinit, initial_value,
        input  incr_valid, incr,
        input  decr_valid, decr,
        input  flag_clear,
        output value, value_next,
        output overflow, underflow,
        output zero, max
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: parametrised up/down counter with wrap or saturate
// overflow handling, sticky over/underflow flags and zero/max status.
module sat_counter #(
    parameter int WIDTH      = 4,
    parameter int STEP_WIDTH = 2,
    parameter bit SATURATE   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    sat_counter_if.slave bus
);
    // Two extra bits: one for carry past the max, one for sign.
    localparam int RW = WIDTH + 2;
    localparam logic [WIDTH-1:0] MAXV = '1;

    logic [WIDTH-1:0] value_q;
    logic             ovf_q;
    logic             unf_q;
    logic             zero_q;
    logic             max_q;

    logic [WIDTH-1:0] base;
    logic [RW-1:0]    base_ext;
    logic [RW-1:0]    inc_ext;
    logic [RW-1:0]    dec_ext;
    logic [RW-1:0]    raw;
    logic             ovf_evt;
    logic             unf_evt;
    logic [WIDTH-1:0] nxt;

    // Net result in two's complement; only the net sum is range-checked.
    always_comb begin
        base     = bus.reinit ? bus.initial_value : value_q;
        base_ext = RW'(base);
        inc_ext  = bus.incr_valid ? RW'(bus.incr) : '0;
        dec_ext  = bus.decr_valid ? RW'(bus.decr) : '0;
        raw      = base_ext + inc_ext - dec_ext;
        unf_evt  = raw[RW-1];
        ovf_evt  = ~raw[RW-1] & raw[WIDTH];
        nxt      = raw[WIDTH-1:0];
        if (SATURATE) begin
            if (ovf_evt) begin
                nxt = MAXV;
            end else if (unf_evt) begin
                nxt = '0;
            end
        end
    end

    // Count, sticky flags and status; a fresh event beats a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= bus.initial_value;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            zero_q  <= (bus.initial_value == '0);
            max_q   <= (bus.initial_value == MAXV);
        end else begin
            value_q <= nxt;
            ovf_q   <= (ovf_q & ~bus.flag_clear) | ovf_evt;
            unf_q   <= (unf_q & ~bus.flag_clear) | unf_evt;
            zero_q  <= (nxt == '0);
            max_q   <= (nxt == MAXV);
        end
    end

    assign bus.value      = value_q;
    assign bus.value_next = nxt;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = unf_q;
    assign bus.zero       = zero_q;
    assign bus.max        = max_q;
endmodule

// File: tb/tb_sat_counter.sv
// tb_sat_counter: directed vectors on a saturating and a wrapping
// instance, expectations queued and checked by a separate monitor.
module tb_sat_counter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sat_counter_if #(.WIDTH(4), .STEP_WIDTH(2)) s_if ();
    sat_counter_if #(.WIDTH(4), .STEP_WIDTH(2)) w_if ();

    sat_counter #(.WIDTH(4), .STEP_WIDTH(2), .SATURATE(1'b1)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if)
    );

    sat_counter #(.WIDTH(4), .STEP_WIDTH(2), .SATURATE(1'b0)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (w_if)
    );

    typedef struct {
        int         d;
        bit         nxt;
        logic [3:0] v;
        logic       o;
        logic       u;
        logic       z;
        logic       m;
        int         due;
        string      nm;
    } exp_t;

    exp_t q[$];

    function automatic logic [7:0] actual(input int d);
        if (d == 0)
            return {s_if.value, s_if.overflow, s_if.underflow,
                    s_if.zero, s_if.max};
        return {w_if.value, w_if.overflow, w_if.underflow,
                w_if.zero, w_if.max};
    endfunction

    function automatic logic [3:0] actual_next(input int d);
        return (d == 0) ? s_if.value_next : w_if.value_next;
    endfunction

    // Monitor: pops every expectation due by this cycle and compares.
    initial begin
        exp_t       e;
        logic [7:0] a;
        logic [7:0] x;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                n_cmp++;
                if (e.nxt) begin
                    if (actual_next(e.d) !== e.v) begin
                        n_bad++;
                        $display("FAIL %s: value_next got %0d need %0d",
                                 e.nm, actual_next(e.d), e.v);
                    end
                end else begin
                    a = actual(e.d);
                    x = {e.v, e.o, e.u, e.z, e.m};
                    if (a !== x) begin
                        n_bad++;
                        $display("FAIL %s: {v,o,u,z,m} got %h/%b need %h/%b",
                                 e.nm, a[7:4], a[3:0], x[7:4], x[3:0]);
                    end
                end
            end
        end
    end

    task automatic set_if(input int d, input bit ri, input logic [3:0] iv,
                          input bit inv, input logic [1:0] inc,
                          input bit dv, input logic [1:0] dec,
                          input bit fc);
        if (d == 0) begin
            s_if.reinit = ri; s_if.initial_value = iv;
            s_if.incr_valid = inv; s_if.incr = inc;
            s_if.decr_valid = dv; s_if.decr = dec;
            s_if.flag_clear = fc;
        end else begin
            w_if.reinit = ri; w_if.initial_value = iv;
            w_if.incr_valid = inv; w_if.incr = inc;
            w_if.decr_valid = dv; w_if.decr = dec;
            w_if.flag_clear = fc;
        end
    endtask

    task automatic push_state(input int d, input logic [3:0] v,
                              input bit o, input bit u, input bit z,
                              input bit m, input string nm);
        exp_t e;
        e.d = d; e.nxt = 1'b0; e.v = v;
        e.o = o; e.u = u; e.z = z; e.m = m;
        e.due = cyc + 1; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic push_next(input int d, input logic [3:0] v,
                             input string nm);
        exp_t e;
        e.d = d; e.nxt = 1'b1; e.v = v;
        e.o = 1'b0; e.u = 1'b0; e.z = 1'b0; e.m = 1'b0;
        e.due = cyc; e.nm = nm;
        q.push_back(e);
    endtask

    // One cycle on instance d; the other instance idles and holds.
    task automatic step(input int d, input bit ri, input logic [3:0] iv,
                        input bit inv, input logic [1:0] inc,
                        input bit dv, input logic [1:0] dec,
                        input bit fc, input bit chk, input logic [3:0] vn,
                        input logic [3:0] ev, input bit eo, input bit eu,
                        input bit ez, input bit em, input string nm);
        logic [3:0] oiv;
        oiv = (d == 0) ? w_if.initial_value : s_if.initial_value;
        @(negedge clk);
        rst_n = 1'b1;
        set_if(1 - d, 1'b0, oiv, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        set_if(d, ri, iv, inv, inc, dv, dec, fc);
        if (chk) push_next(d, vn, {nm, "_next"});
        push_state(d, ev, eo, eu, ez, em, nm);
    endtask

    task automatic do_reset(input logic [3:0] ivs, input logic [3:0] ivw,
                            input bit inv, input string nm);
        @(negedge clk);
        rst_n = 1'b0;
        set_if(0, 1'b0, ivs, inv, 2'd3, 1'b0, 2'd0, 1'b0);
        set_if(1, 1'b0, ivw, inv, 2'd3, 1'b0, 2'd0, 1'b0);
        push_state(0, ivs, 1'b0, 1'b0, ivs == 4'd0, ivs == 4'hf,
                   {nm, "_sat"});
        push_state(1, ivw, 1'b0, 1'b0, ivw == 4'd0, ivw == 4'hf,
                   {nm, "_wrap"});
    endtask

    initial begin
        set_if(0, 1'b0, 4'd5, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        set_if(1, 1'b0, 4'd5, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);

        do_reset(4'd5, 4'd5, 1'b0, "reset_load");
        //   d ri iv  iv inc dv dec fc chk vn    ev  o u z m
        step(0, 0, 4'd5, 0, 2'd0, 0, 2'd0, 0, 0, 4'd0,
             4'd5, 0, 0, 0, 0, "hold_5");
        step(0, 1, 4'd3, 0, 2'd0, 0, 2'd0, 0, 0, 4'd0,
             4'd3, 0, 0, 0, 0, "reinit_3");
        step(0, 0, 4'd3, 1, 2'd2, 1, 2'd1, 0, 1, 4'd4,
             4'd4, 0, 0, 0, 0, "net_update");
        step(0, 1, 4'd14, 0, 2'd0, 0, 2'd0, 0, 0, 4'd0,
             4'd14, 0, 0, 0, 0, "reinit_14");
        step(0, 0, 4'd14, 1, 2'd3, 0, 2'd0, 0, 1, 4'd15,
             4'd15, 1, 0, 0, 1, "sat_high");
        step(0, 0, 4'd14, 0, 2'd0, 0, 2'd0, 1, 1, 4'd15,
             4'd15, 0, 0, 0, 1, "clear_ovf");
        step(0, 0, 4'd14, 1, 2'd3, 0, 2'd0, 0, 0, 4'd0,
             4'd15, 1, 0, 0, 1, "sat_again");
        step(0, 1, 4'd0, 0, 2'd0, 1, 2'd2, 0, 1, 4'd0,
             4'd0, 1, 1, 1, 0, "reinit_decr");
        step(0, 1, 4'd14, 1, 2'd3, 0, 2'd0, 1, 1, 4'd15,
             4'd15, 1, 0, 0, 1, "clear_collide");
        step(0, 0, 4'd14, 0, 2'd0, 0, 2'd0, 0, 0, 4'd0,
             4'd15, 1, 0, 0, 1, "hold_15");

        step(1, 1, 4'd1, 0, 2'd0, 0, 2'd0, 0, 0, 4'd0,
             4'd1, 0, 0, 0, 0, "w_reinit_1");
        step(1, 0, 4'd1, 0, 2'd0, 1, 2'd3, 0, 1, 4'd14,
             4'd14, 0, 1, 0, 0, "wrap_low");
        step(1, 0, 4'd1, 1, 2'd3, 0, 2'd0, 0, 1, 4'd1,
             4'd1, 1, 1, 0, 0, "wrap_high");
        step(1, 1, 4'd15, 0, 2'd0, 0, 2'd0, 0, 0, 4'd0,
             4'd15, 1, 1, 0, 1, "w_reinit_15");
        step(1, 0, 4'd15, 1, 2'd1, 1, 2'd1, 1, 1, 4'd15,
             4'd15, 0, 0, 0, 1, "w_net_at_max");
        step(1, 1, 4'd0, 1, 2'd3, 1, 2'd3, 0, 1, 4'd0,
             4'd0, 0, 0, 1, 0, "w_net_at_zero");

        step(0, 0, 4'd14, 1, 2'd1, 0, 2'd0, 0, 0, 4'd0,
             4'd15, 1, 0, 0, 1, "pre_reset");
        do_reset(4'd7, 4'd0, 1'b1, "reset_mid");
        step(0, 0, 4'd7, 0, 2'd0, 0, 2'd0, 0, 0, 4'd0,
             4'd7, 0, 0, 0, 0, "hold_after_reset");

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #4;
        if (q.size() > 0) begin
            n_bad += q.size();
            $display("FAIL drain: %0d expectations left, need 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
